// File: rtl/arith_unit_mc_if.sv
// ---------------------------------------------------------------------------
// arith_unit_mc_if
// Request/response bundle between the ALU decoder, arith_unit_mc and the
// result mux.
//
// Handshake (both directions): a transfer happens on a rising clock edge
// where the producer's valid and the consumer's ready are both high. A
// producer may raise valid at any time. Once the unit raises Out_Valid it
// holds the result and flags stable until that transfer happens. The unit
// never makes In_Ready depend on In_Valid.
//
// Signals:
//   A, B         operands (dividend / divisor for DIV)
//   ALU_FUN      00 ADD, 01 SUB, 10 MUL, 11 DIV
//   Signed_Mode  1 = two's-complement operands
//   In_Valid     request valid            In_Ready   unit idle, can accept
//   Out_Valid    result valid             Out_Ready  consumer takes result
//   Arith_out    2N-bit result
//   Carry_OUT, Overflow, Zero_Flag, Div_By_Zero   result flags
// Modports: master = requester/consumer side, slave = arithmetic unit.
// ---------------------------------------------------------------------------
interface arith_unit_mc_if #(
  parameter int OPERAND_SIZE = 16
);
  logic [OPERAND_SIZE-1:0]   A;
  logic [OPERAND_SIZE-1:0]   B;
  logic [1:0]                ALU_FUN;
  logic                      Signed_Mode;
  logic                      In_Valid;
  logic                      In_Ready;
  logic                      Out_Ready;
  logic                      Out_Valid;
  logic [2*OPERAND_SIZE-1:0] Arith_out;
  logic                      Carry_OUT;
  logic                      Overflow;
  logic                      Zero_Flag;
  logic                      Div_By_Zero;

  modport master (
    output A, B, ALU_FUN, Signed_Mode, In_Valid, Out_Ready,
    input  In_Ready, Out_Valid, Arith_out, Carry_OUT, Overflow, Zero_Flag,
           Div_By_Zero
  );

  modport slave (
    input  A, B, ALU_FUN, Signed_Mode, In_Valid, Out_Ready,
    output In_Ready, Out_Valid, Arith_out, Carry_OUT, Overflow, Zero_Flag,
           Div_By_Zero
  );
endinterface

// File: rtl/arith_unit_mc.sv
// ---------------------------------------------------------------------------
// arith_unit_mc
// Multi-cycle arithmetic unit. It performs ADD, SUB, MUL and DIV on
// OPERAND_SIZE-bit operands, in unsigned or signed mode.
// - ADD/SUB, and DIV by zero, complete at the accept edge.
// - MUL uses an iterative shift-add datapath. DIV uses iterative restoring
//   division. Each takes OPERAND_SIZE iteration edges after the accept edge.
//
// Ports:
//   CLK          rising-edge clock
//   RST          synchronous active-high reset; aborts any operation
//   bus          arith_unit_mc_if.slave (operands, handshake, result, flags)
//   o_dbg_state  current FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// ALU_OUT must equal 2*OPERAND_SIZE.
// ---------------------------------------------------------------------------
module arith_unit_mc #(
  parameter int OPERAND_SIZE = 16,
  parameter int ALU_OUT      = 2*OPERAND_SIZE
) (
  input  logic            CLK,
  input  logic            RST,
  arith_unit_mc_if.slave  bus,
  output logic [1:0]      o_dbg_state
);
  localparam int N  = OPERAND_SIZE;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_ITER = CW'(N-1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;
  logic   w_accept, w_last, w_fast;

  // Working registers shared by MUL and DIV.
  // MUL: {r_hi, r_lo} is the shifting product; r_lo starts as |A|.
  // DIV: r_hi is the partial remainder; r_lo shifts the dividend out and the
  //      quotient in.
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_hi, r_lo, r_b;
  logic          r_is_div, r_neg_q, r_neg_r, r_ovf_pend;

  logic [ALU_OUT-1:0] r_arith_out;
  logic               r_carry, r_ovf, r_zero, r_dbz;

  // Values captured at the accept edge.
  logic               w_a_neg, w_b_neg;
  logic [N-1:0]       w_a_mag, w_b_mag;
  logic [ALU_OUT-1:0] w_a_ext, w_b_ext, w_sum_ext, w_fast_out;
  logic               w_fast_carry, w_fast_ovf, w_fast_dbz;

  // One iteration step.
  logic [N:0]         w_mul_sum, w_div_sh;
  logic [N-1:0]       w_div_sub;
  logic               w_div_ge;
  logic [N-1:0]       w_hi_nxt, w_lo_nxt, w_q_fix, w_r_fix;
  logic [ALU_OUT-1:0] w_prod, w_slow_out;

  assign bus.In_Ready    = (r_state == S_IDLE);
  assign bus.Out_Valid   = (r_state == S_DONE);
  assign bus.Arith_out   = r_arith_out;
  assign bus.Carry_OUT   = r_carry;
  assign bus.Overflow    = r_ovf;
  assign bus.Zero_Flag   = r_zero;
  assign bus.Div_By_Zero = r_dbz;
  assign o_dbg_state     = r_state;

  // ADD/SUB and DIV-by-zero finish in the accept edge.
  assign w_fast = !bus.ALU_FUN[1] || (bus.ALU_FUN[0] && (bus.B == '0));

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.In_Valid) begin
          w_accept    = 1'b1;
          w_state_nxt = w_fast ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_cnt == LAST_ITER) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.Out_Ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Single-cycle path. The signed sum is exact in 2N bits. The N-bit
  // overflow shows up as a disagreement between bits N and N-1.
  always_comb begin
    w_a_neg   = bus.Signed_Mode & bus.A[N-1];
    w_b_neg   = bus.Signed_Mode & bus.B[N-1];
    w_a_mag   = w_a_neg ? -bus.A : bus.A;
    w_b_mag   = w_b_neg ? -bus.B : bus.B;
    w_a_ext   = bus.Signed_Mode ? {{N{bus.A[N-1]}}, bus.A} : {{N{1'b0}}, bus.A};
    w_b_ext   = bus.Signed_Mode ? {{N{bus.B[N-1]}}, bus.B} : {{N{1'b0}}, bus.B};
    w_sum_ext = bus.ALU_FUN[0] ? (w_a_ext - w_b_ext) : (w_a_ext + w_b_ext);

    w_fast_out   = '0;
    w_fast_carry = 1'b0;
    w_fast_ovf   = 1'b0;
    w_fast_dbz   = 1'b0;
    if (bus.ALU_FUN[1]) begin
      // Divide by zero: quotient all ones, remainder = raw dividend.
      w_fast_out = {bus.A, {N{1'b1}}};
      w_fast_dbz = 1'b1;
    end else if (bus.Signed_Mode) begin
      w_fast_out = w_sum_ext;
      w_fast_ovf = w_sum_ext[N] ^ w_sum_ext[N-1];
    end else begin
      w_fast_out   = {{N{1'b0}}, w_sum_ext[N-1:0]};
      w_fast_carry = bus.ALU_FUN[0] ? (bus.A < bus.B) : w_sum_ext[N];
    end
  end

  // Iteration datapath. The DIV difference is taken in N bits because it is
  // used only when the shifted remainder is >= divisor, so it fits.
  always_comb begin
    w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_div_sh  = {r_hi, r_lo[N-1]};
    w_div_ge  = (w_div_sh >= {1'b0, r_b});
    w_div_sub = w_div_sh[N-1:0] - r_b;
    if (r_is_div) begin
      w_hi_nxt = w_div_ge ? w_div_sub : w_div_sh[N-1:0];
      w_lo_nxt = {r_lo[N-2:0], w_div_ge};
    end else begin
      w_hi_nxt = w_mul_sum[N:1];
      w_lo_nxt = {w_mul_sum[0], r_lo[N-1:1]};
    end
    // Sign fix-up applied to the values produced by the last iteration.
    w_prod     = {w_hi_nxt, w_lo_nxt};
    w_q_fix    = r_neg_q ? -w_lo_nxt : w_lo_nxt;
    w_r_fix    = r_neg_r ? -w_hi_nxt : w_hi_nxt;
    w_slow_out = r_is_div ? {w_r_fix, w_q_fix} : (r_neg_q ? -w_prod : w_prod);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_b         <= '0;
      r_is_div    <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_ovf_pend  <= 1'b0;
      r_arith_out <= '0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt    <= '0;
        r_hi     <= '0;
        r_lo     <= w_a_mag;
        r_b      <= w_b_mag;
        r_is_div <= bus.ALU_FUN[0];
        r_neg_q  <= w_a_neg ^ w_b_neg;
        r_neg_r  <= w_a_neg;
        // Most negative / -1: the magnitude quotient 2^(N-1) already reads
        // back as -2^(N-1), so only the flag needs to be set.
        r_ovf_pend <= bus.Signed_Mode && bus.ALU_FUN[0] &&
                      (bus.A == {1'b1, {(N-1){1'b0}}}) && (bus.B == '1);
        if (w_fast) begin
          r_arith_out <= w_fast_out;
          r_carry     <= w_fast_carry;
          r_ovf       <= w_fast_ovf;
          r_zero      <= (w_fast_out == '0);
          r_dbz       <= w_fast_dbz;
        end
      end else if (r_state == S_BUSY) begin
        r_hi  <= w_hi_nxt;
        r_lo  <= w_lo_nxt;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_arith_out <= w_slow_out;
          r_carry     <= 1'b0;
          r_ovf       <= r_ovf_pend;
          r_zero      <= (w_slow_out == '0);
          r_dbz       <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_arith_unit_mc.sv
// ---------------------------------------------------------------------------
// tb_arith_unit_mc
// Bench for arith_unit_mc with OPERAND_SIZE = 16. Expected results are
// packed as {Arith_out, Carry_OUT, Overflow, Zero_Flag, Div_By_Zero}.
// ---------------------------------------------------------------------------
module tb_arith_unit_mc;
  localparam int N = 16;
  localparam int W = 2*N + 4;

  typedef struct {
    logic [1:0]   fun;
    logic         sgn;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2*N-1:0] out;
    logic         c;
    logic         v;
    logic         z;
    logic         dbz;
    int           lat;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         n_tests;
  int         n_fail;
  logic [W-1:0] exp_q[$];
  vec_t       vecs[16];

  arith_unit_mc_if #(.OPERAND_SIZE(N)) bus ();

  arith_unit_mc #(.OPERAND_SIZE(N)) dut (
    .CLK         (clk),
    .RST         (rst),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---- checking helpers ----
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] got_packed();
    return {bus.Arith_out, bus.Carry_OUT, bus.Overflow, bus.Zero_Flag, bus.Div_By_Zero};
  endfunction

  function automatic vec_t mk(input logic [1:0] fun, input logic sgn,
                              input logic [N-1:0] a, input logic [N-1:0] b,
                              input logic [2*N-1:0] out, input logic c,
                              input logic v, input logic dbz, input int lat);
    vec_t t;
    t.fun = fun; t.sgn = sgn; t.a = a; t.b = b; t.out = out;
    t.c = c; t.v = v; t.z = (out == '0); t.dbz = dbz; t.lat = lat;
    return t;
  endfunction

  // ---- driver: issue a request, time the response, drain it ----
  // hold: cycles Out_Ready stays low in DONE (outputs checked stable).
  // poke: raise In_Valid during BUSY and on the releasing edge.
  task automatic run_op(input string name, input logic [1:0] fun, input logic sgn,
                        input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [W-1:0] exp, input int exp_lat,
                        input int hold, input bit poke);
    int cyc;
    logic [W-1:0] want;
    cyc = 0;
    while (!bus.In_Ready && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    check({name, " in_ready"}, 64'(bus.In_Ready), 64'(1));
    bus.A = a; bus.B = b; bus.ALU_FUN = fun; bus.Signed_Mode = sgn;
    bus.In_Valid = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    // Scramble the inputs; the unit must have captured them already.
    bus.In_Valid = 1'b0;
    bus.A = N'($urandom); bus.B = N'($urandom);
    bus.ALU_FUN = 2'($urandom); bus.Signed_Mode = 1'($urandom);
    cyc = 1;
    while (!bus.Out_Valid && cyc < 40) begin
      bus.In_Valid = poke && (cyc == 3);
      @(posedge clk); #1; cyc++;
    end
    bus.In_Valid = 1'b0;
    if (!bus.Out_Valid) begin
      n_tests++; n_fail++;
      $display("FAIL %s timeout: no Out_Valid after %0d cycles, expected %0d", name, cyc, exp_lat);
      void'(exp_q.pop_front());
      return;
    end
    check({name, " latency"}, 64'(cyc), 64'(exp_lat));
    want = exp_q.pop_front();
    for (int h = 0; h < hold; h++) begin
      check({name, " hold out"}, 64'(got_packed()), 64'(want));
      check({name, " hold in_ready"}, 64'(bus.In_Ready), 64'(0));
      @(posedge clk); #1;
    end
    check({name, " result"}, 64'(got_packed()), 64'(want));
    bus.Out_Ready = 1'b1;
    bus.In_Valid  = poke;
    @(posedge clk); #1;
    bus.Out_Ready = 1'b0;
    bus.In_Valid  = 1'b0;
    check({name, " back to idle"}, 64'(dbg_state), 64'(0));
  endtask

  // Reference for unsigned random operations.
  function automatic logic [W-1:0] model_u(input logic [1:0] fun,
                                           input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0]     s;
    logic [2*N-1:0] o;
    logic           c, d;
    c = 1'b0; d = 1'b0;
    case (fun)
      2'b00: begin s = {1'b0, a} + {1'b0, b}; o = {{N{1'b0}}, s[N-1:0]}; c = s[N]; end
      2'b01: begin o = {{N{1'b0}}, N'(a - b)}; c = (a < b); end
      2'b10: o = {{N{1'b0}}, a} * {{N{1'b0}}, b};
      default: begin
        if (b == '0) begin o = {a, {N{1'b1}}}; d = 1'b1; end
        else o = {N'(a % b), N'(a / b)};
      end
    endcase
    return {o, c, 1'b0, (o == '0), d};
  endfunction

  initial begin
    logic [1:0]   rf;
    logic [N-1:0] ra, rb;
    int           rl;
    n_tests = 0;
    n_fail  = 0;
    bus.A = '0; bus.B = '0; bus.ALU_FUN = 2'b00; bus.Signed_Mode = 1'b0;
    bus.In_Valid = 1'b0; bus.Out_Ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    check("reset in_ready", 64'(bus.In_Ready), 64'(1));
    check("reset out_valid", 64'(bus.Out_Valid), 64'(0));
    check("reset outputs", 64'(got_packed()), 64'(0));

    //             fun    sgn   a         b         out            c     v     dbz   lat
    vecs[0]  = mk(2'b00, 1'b0, 16'hFFFF, 16'h0001, 32'h00000000, 1'b1, 1'b0, 1'b0, 1);
    vecs[1]  = mk(2'b01, 1'b1, 16'h8000, 16'h0001, 32'hFFFF7FFF, 1'b0, 1'b1, 1'b0, 1);
    vecs[2]  = mk(2'b10, 1'b1, 16'hFFFD, 16'h0007, 32'hFFFFFFEB, 1'b0, 1'b0, 1'b0, 17);
    vecs[3]  = mk(2'b10, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b0, 1'b0, 1'b0, 17);
    vecs[4]  = mk(2'b11, 1'b0, 16'd100,  16'd7,    32'h0002000E, 1'b0, 1'b0, 1'b0, 17);
    vecs[5]  = mk(2'b11, 1'b1, 16'hFF9C, 16'd7,    32'hFFFEFFF2, 1'b0, 1'b0, 1'b0, 17);
    vecs[6]  = mk(2'b11, 1'b1, 16'h8000, 16'hFFFF, 32'h00008000, 1'b0, 1'b1, 1'b0, 17);
    vecs[7]  = mk(2'b11, 1'b0, 16'h1234, 16'h0000, 32'h1234FFFF, 1'b0, 1'b0, 1'b1, 1);
    vecs[8]  = mk(2'b00, 1'b1, 16'h7FFF, 16'h0001, 32'h00008000, 1'b0, 1'b1, 1'b0, 1);
    vecs[9]  = mk(2'b01, 1'b0, 16'h0003, 16'h0005, 32'h0000FFFE, 1'b1, 1'b0, 1'b0, 1);
    vecs[10] = mk(2'b00, 1'b0, 16'h1234, 16'h4321, 32'h00005555, 1'b0, 1'b0, 1'b0, 1);
    vecs[11] = mk(2'b10, 1'b1, 16'h8000, 16'h8000, 32'h40000000, 1'b0, 1'b0, 1'b0, 17);
    vecs[12] = mk(2'b11, 1'b1, 16'd100,  16'hFFF9, 32'h0002FFF2, 1'b0, 1'b0, 1'b0, 17);
    vecs[13] = mk(2'b10, 1'b0, 16'h0000, 16'h1234, 32'h00000000, 1'b0, 1'b0, 1'b0, 17);
    vecs[14] = mk(2'b01, 1'b1, 16'h0005, 16'h0005, 32'h00000000, 1'b0, 1'b0, 1'b0, 1);
    vecs[15] = mk(2'b11, 1'b1, 16'hFF9C, 16'h0000, 32'hFF9CFFFF, 1'b0, 1'b0, 1'b1, 1);

    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].fun, vecs[i].sgn, vecs[i].a, vecs[i].b,
             {vecs[i].out, vecs[i].c, vecs[i].v, vecs[i].z, vecs[i].dbz},
             vecs[i].lat, $urandom_range(0, 2), 1'b0);
    end

    // Random unsigned operations against the reference function.
    for (int k = 0; k < 8; k++) begin
      rf = 2'($urandom_range(0, 3));
      ra = N'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom);
      rl = (!rf[1] || (rf[0] && rb == '0)) ? 1 : 17;
      run_op($sformatf("rand%0d", k), rf, 1'b0, ra, rb, model_u(rf, ra, rb), rl,
             $urandom_range(0, 1), 1'b0);
    end

    // DONE held for 5 cycles: outputs stable and In_Ready low.
    run_op("hold5", 2'b00, 1'b0, 16'hFFFF, 16'h0001, {32'h00000000, 4'b1010}, 1, 5, 1'b0);

    // In_Valid pulsed during BUSY and on the releasing edge must be ignored.
    run_op("busy_poke", 2'b10, 1'b1, 16'hFFFD, 16'h0007, {32'hFFFFFFEB, 4'b0000}, 17, 2, 1'b1);
    repeat (3) @(posedge clk);
    #1 check("busy_poke no extra result", 64'(bus.Out_Valid), 64'(0));

    // Reset at MUL iteration 8, with nonzero outputs left from a DIV by zero.
    run_op("pre_reset", 2'b11, 1'b0, 16'h1234, 16'h0000, {32'h1234FFFF, 4'b0001}, 1, 0, 1'b0);
    bus.A = 16'h0123; bus.B = 16'h0045; bus.ALU_FUN = 2'b10; bus.Signed_Mode = 1'b0;
    bus.In_Valid = 1'b1;
    @(posedge clk); #1;
    bus.In_Valid = 1'b0;
    check("mid_reset busy", 64'(dbg_state), 64'(1));
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_reset state", 64'(dbg_state), 64'(0));
    check("mid_reset in_ready", 64'(bus.In_Ready), 64'(1));
    check("mid_reset out_valid", 64'(bus.Out_Valid), 64'(0));
    check("mid_reset outputs", 64'(got_packed()), 64'(0));
    repeat (20) @(posedge clk);
    #1 check("mid_reset aborted", 64'(bus.Out_Valid), 64'(0));

    // Unit is usable again after the abort.
    run_op("post_reset", 2'b10, 1'b0, 16'h0123, 16'h0045, {32'h00004E6F, 4'b0000}, 17, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
